// File: rtl/posit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : posit_pkg
// Description : Shared types and special-value constants for the posit
//               regime decoder.
// Revision    : 1.0 - initial release
// ============================================================================
package posit_pkg;

    localparam int C_WORD_SIZE = 32;
    localparam int C_RS        = 5;
    localparam int C_MAX_WORD  = 64;

    typedef logic signed [C_RS:0] regime_t;

    typedef struct packed {
        logic                   sign;
        regime_t                k;
        logic [C_RS-1:0]        shamt;
        logic [C_WORD_SIZE-1:0] body;
        logic                   zero;
        logic                   nar;
    } s2_payload_t;

    // NaR is a lone 1 in the MSB; zero is all zeros. Callers slice to width n.
    function automatic logic [C_MAX_WORD-1:0] special_word(input int n, input logic is_nar);
        return is_nar ? (C_MAX_WORD'(1) << (n - 1)) : {C_MAX_WORD{1'b0}};
    endfunction

endpackage
`default_nettype wire

// File: rtl/posit_run_detect.sv
`default_nettype none
// ============================================================================
// Module      : posit_run_detect
// Description : Combinational regime run-length counter, log-depth priority
//               tree over the body bits.
// Revision    : 1.0 - initial release
// ============================================================================
module posit_run_detect #(
    parameter int WORD_SIZE = 32,
    parameter int RS        = 5
) (
    input  logic [WORD_SIZE-2:0] body,
    input  logic                 r,
    output logic [RS-1:0]        m
);

    // Bits equal to r become 0; a trailing 1 pads to a power of two and caps
    // the count at WORD_SIZE-1 when the whole body is one run.
    logic [WORD_SIZE-1:0] w_vec;
    assign w_vec = {body ^ {(WORD_SIZE-1){r}}, 1'b1};

    genvar l, j;
    generate
        for (l = 0; l <= RS; l++) begin : g_lvl
            localparam int NODES = WORD_SIZE >> l;
            logic [RS-1:0] cnt [NODES];
            logic          vld [NODES];
            for (j = 0; j < NODES; j++) begin : g_node
                if (l == 0) begin : g_leaf
                    assign vld[j] = w_vec[WORD_SIZE-1-j];
                    assign cnt[j] = '0;
                end else begin : g_merge
                    assign vld[j] = g_lvl[l-1].vld[2*j] | g_lvl[l-1].vld[2*j+1];
                    assign cnt[j] = g_lvl[l-1].vld[2*j] ? g_lvl[l-1].cnt[2*j]
                                  : RS'(1 << (l - 1)) + g_lvl[l-1].cnt[2*j+1];
                end
            end
        end
    endgenerate

    assign m = g_lvl[RS].vld[0] ? g_lvl[RS].cnt[0] : '0;

endmodule
`default_nettype wire

// File: rtl/posit_regime_decoder.sv
`default_nettype none
// ============================================================================
// Module      : posit_regime_decoder
// Description : Two-stage posit front end: sign/abs, regime run length,
//               k / shift amount / pre-aligned body. PRD_SKID_EN adds a
//               registered-ready two-entry input skid buffer.
// Revision    : 1.0 - initial release
// ============================================================================
module posit_regime_decoder
    import posit_pkg::*;
#(
    parameter int WORD_SIZE = 32,
    parameter int RS        = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WORD_SIZE-1:0] in_posit,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_sign,
    output logic signed [RS:0]   out_k,
    output logic [RS-1:0]        out_shamt,
    output logic [WORD_SIZE-1:0] out_body,
    output logic                 out_zero,
    output logic                 out_nar
);

    localparam logic [WORD_SIZE-1:0] c_nar       = WORD_SIZE'(special_word(WORD_SIZE, 1'b1));
    localparam logic [WORD_SIZE-1:0] c_zero      = WORD_SIZE'(special_word(WORD_SIZE, 1'b0));
    localparam logic [RS-1:0]        c_shamt_max = RS'(WORD_SIZE - 1);

    typedef struct packed {
        logic                   sign;
        logic signed [RS:0]     k;
        logic [RS-1:0]          shamt;
        logic [WORD_SIZE-1:0]   body;
        logic                   zero;
        logic                   nar;
    } payload_t;

    logic                 r_s1_valid;
    logic                 r_s1_sign;
    logic                 r_s1_zero;
    logic                 r_s1_nar;
    logic [WORD_SIZE-2:0] r_s1_body;
    logic                 r_s2_valid;
    payload_t             r_s2;

    logic                 w_s2_adv;
    logic                 w_s1_adv;
    logic                 w_s1_load;
    logic [WORD_SIZE-1:0] w_s1_word;

    assign w_s2_adv = !r_s2_valid || out_ready;
    assign w_s1_adv = !r_s1_valid || w_s2_adv;

`ifdef PRD_SKID_EN
    logic [WORD_SIZE-1:0] r_sk_data [2];
    logic [1:0]           r_sk_cnt;
    logic                 r_in_ready;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_store;
    logic                 w_buf_nonempty;
    logic [1:0]           w_sk_cnt_nxt;

    // An empty buffer is bypassed so latency matches the non-skid build.
    assign in_ready       = r_in_ready;
    assign w_push         = in_valid && r_in_ready;
    assign w_buf_nonempty = (r_sk_cnt != 2'd0);
    assign w_s1_load      = w_s1_adv && (w_buf_nonempty || w_push);
    assign w_s1_word      = w_buf_nonempty ? r_sk_data[0] : in_posit;
    assign w_pop          = w_s1_load && w_buf_nonempty;
    assign w_store        = w_push && !(w_s1_load && !w_buf_nonempty);
    assign w_sk_cnt_nxt   = r_sk_cnt - {1'b0, w_pop} + {1'b0, w_store};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sk_cnt     <= 2'd0;
            r_in_ready   <= 1'b0;
            r_sk_data[0] <= '0;
            r_sk_data[1] <= '0;
        end else begin
            r_sk_cnt   <= w_sk_cnt_nxt;
            r_in_ready <= (w_sk_cnt_nxt != 2'd2);
            if (w_pop)
                r_sk_data[0] <= r_sk_data[1];
            if (w_store) begin
                if ((r_sk_cnt - {1'b0, w_pop}) == 2'd0)
                    r_sk_data[0] <= in_posit;
                else
                    r_sk_data[1] <= in_posit;
            end
        end
    end
`else
    logic r_ready_en;

    assign in_ready  = r_ready_en && w_s1_adv;
    assign w_s1_load = in_valid && in_ready;
    assign w_s1_word = in_posit;

    always_ff @(posedge clk) begin
        if (!rst_n)
            r_ready_en <= 1'b0;
        else
            r_ready_en <= 1'b1;
    end
`endif

    // Low N-1 bits of -x depend only on the low N-1 bits of x.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_sign  <= 1'b0;
            r_s1_zero  <= 1'b0;
            r_s1_nar   <= 1'b0;
            r_s1_body  <= '0;
        end else if (w_s1_adv) begin
            r_s1_valid <= w_s1_load;
            if (w_s1_load) begin
                r_s1_sign <= w_s1_word[WORD_SIZE-1];
                r_s1_body <= w_s1_word[WORD_SIZE-1] ? -w_s1_word[WORD_SIZE-2:0]
                                                    :  w_s1_word[WORD_SIZE-2:0];
                r_s1_zero <= (w_s1_word == c_zero);
                r_s1_nar  <= (w_s1_word == c_nar);
            end
        end
    end

    logic               w_r;
    logic [RS-1:0]      w_m;
    logic signed [RS:0] w_m_ext;
    logic signed [RS:0] w_k;
    logic [RS-1:0]      w_shamt;
    logic               w_special;
    payload_t           w_s2_nxt;

    assign w_r = r_s1_body[WORD_SIZE-2];

    posit_run_detect #(
        .WORD_SIZE (WORD_SIZE),
        .RS        (RS)
    ) u_run_detect (
        .body (r_s1_body),
        .r    (w_r),
        .m    (w_m)
    );

    assign w_m_ext   = signed'({1'b0, w_m});
    assign w_k       = w_r ? (w_m_ext - (RS+1)'(1)) : -w_m_ext;
    assign w_shamt   = (w_m == c_shamt_max) ? c_shamt_max : w_m + RS'(1);
    assign w_special = r_s1_zero || r_s1_nar;

    assign w_s2_nxt.sign  = r_s1_sign;
    assign w_s2_nxt.k     = w_special ? '0 : w_k;
    assign w_s2_nxt.shamt = w_special ? '0 : w_shamt;
    assign w_s2_nxt.body  = w_special ? '0 : {r_s1_body, 1'b0};
    assign w_s2_nxt.zero  = r_s1_zero;
    assign w_s2_nxt.nar   = r_s1_nar;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s2_valid <= 1'b0;
            r_s2       <= '0;
        end else if (w_s2_adv) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid)
                r_s2 <= w_s2_nxt;
        end
    end

    assign out_valid = r_s2_valid;
    assign out_sign  = r_s2.sign;
    assign out_k     = r_s2.k;
    assign out_shamt = r_s2.shamt;
    assign out_body  = r_s2.body;
    assign out_zero  = r_s2.zero;
    assign out_nar   = r_s2.nar;

endmodule
`default_nettype wire
